// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA pixel unpacker: colour modes, FSM states,
// per-mode pixel widths and the last-lane lookup.
package vga_pkg;

   typedef enum logic [1:0] {
      VGA_MODE_GREY8    = 2'b00,
      VGA_MODE_RGB565   = 2'b01,
      VGA_MODE_XRGB8888 = 2'b10
   } vga_mode_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } unpack_state_e;

   localparam int BPP_GREY8    = 8;
   localparam int BPP_RGB565   = 16;
   localparam int BPP_XRGB8888 = 32;

   function automatic logic [2:0] mode_last_lane(input vga_mode_e mode);
      case (mode)
         VGA_MODE_GREY8:  mode_last_lane = 3'd7;
         VGA_MODE_RGB565: mode_last_lane = 3'd3;
         default:         mode_last_lane = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/vga_pixel_unpack_if.sv
// Word stream from the tx FIFO and pixel stream to the timing generator.
// slave: the unpacker's view; master: the surrounding FIFO/timing-generator view.
interface vga_pixel_unpack_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int COLOR_WIDTH = 8
);
   logic                   word_valid_i;
   logic                   word_ready_o;
   logic [DATA_WIDTH-1:0]  word_data_i;
   logic                   pix_valid_o;
   logic                   pix_ready_i;
   logic [COLOR_WIDTH-1:0] pix_r_o;
   logic [COLOR_WIDTH-1:0] pix_g_o;
   logic [COLOR_WIDTH-1:0] pix_b_o;

   modport slave (
      input  word_valid_i, word_data_i, pix_ready_i,
      output word_ready_o, pix_valid_o, pix_r_o, pix_g_o, pix_b_o
   );

   modport master (
      output word_valid_i, word_data_i, pix_ready_i,
      input  word_ready_o, pix_valid_o, pix_r_o, pix_g_o, pix_b_o
   );
endinterface

// File: rtl/vga_pixel_expand.sv
// Combinational lane select and colour expansion of one pixel from a 64-bit word.
module vga_pixel_expand
   import vga_pkg::*;
(
   input  vga_mode_e   mode,
   input  logic [2:0]  lane,
   input  logic [63:0] word,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b
);

   logic [7:0]  grey;
   logic [15:0] p565;
   logic [23:0] p888;

   assign grey = word[{lane, 3'b000} +: BPP_GREY8];
   assign p565 = word[{lane[1:0], 4'b0000} +: BPP_RGB565];
   // the X byte of XRGB8888 is never selected
   assign p888 = word[{lane[0], 5'b00000} +: 24];

   always_comb begin
      r = '0;
      g = '0;
      b = '0;
      case (mode)
         VGA_MODE_GREY8: begin
            r = grey;
            g = grey;
            b = grey;
         end
         VGA_MODE_RGB565: begin
            r = {p565[15:11], p565[15:13]};
            g = {p565[10:5],  p565[10:9]};
            b = {p565[4:0],   p565[4:2]};
         end
         default: begin
            r = p888[23:16];
            g = p888[15:8];
            b = p888[7:0];
         end
      endcase
   end

endmodule

// File: rtl/vga_pixel_unpack.sv
// Splits 64-bit frame-buffer words into 8/4/2 pixels and streams them as 8-bit RGB.
// Build option VGA_UNPACK_OUTREG_EN adds a 2-entry registered skid stage on the pixel stream.
//
//  state    | meaning
//  ST_EMPTY | no word held; pop the FIFO when enabled
//  ST_FULL  | word held in data_q, lane_q selects the pixel on offer
module vga_pixel_unpack
   import vga_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int COLOR_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic                 flush_i,
   input  logic [1:0]           mode_i,
   vga_pixel_unpack_if.slave    bus,
   output logic                 underrun_o
);

   if (DATA_WIDTH != 64 || COLOR_WIDTH != 8) begin : g_bad_cfg
      $error("vga_pixel_unpack: DATA_WIDTH must be 64 and COLOR_WIDTH must be 8");
   end

   unpack_state_e state_q;
   logic [63:0]   data_q;
   logic [2:0]    lane_q;
   vga_mode_e     mode_q;
   logic          underrun_q;

   vga_mode_e     mode_in;
   logic          core_valid;
   logic          core_ready;
   logic          core_fire;
   logic          last_lane;
   logic          word_ready;
   logic          load;
   logic [7:0]    exp_r, exp_g, exp_b;

   assign mode_in    = (mode_i == 2'b11) ? VGA_MODE_XRGB8888 : vga_mode_e'(mode_i);
   assign core_valid = en_i & (state_q == ST_FULL);
   assign core_fire  = core_valid & core_ready;
   assign last_lane  = (lane_q == mode_last_lane(mode_q));
   // refill in the same cycle the last lane goes out, so words run back to back
   assign word_ready = en_i & ~flush_i & ((state_q == ST_EMPTY) | (core_fire & last_lane));
   assign load       = word_ready & bus.word_valid_i;

   assign bus.word_ready_o = word_ready;
   assign underrun_o       = underrun_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_EMPTY;
         data_q     <= '0;
         lane_q     <= '0;
         mode_q     <= VGA_MODE_GREY8;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= ~flush_i & en_i & bus.pix_ready_i & ~bus.pix_valid_o;
         if (flush_i) begin
            state_q <= ST_EMPTY;
            lane_q  <= '0;
         end else if (load) begin
            state_q <= ST_FULL;
            data_q  <= bus.word_data_i;
            mode_q  <= mode_in;
            lane_q  <= '0;
         end else if (core_fire) begin
            if (last_lane) begin
               state_q <= ST_EMPTY;
               lane_q  <= '0;
            end else begin
               lane_q  <= lane_q + 3'd1;
            end
         end
      end
   end

   vga_pixel_expand u_expand (
      .mode (mode_q),
      .lane (lane_q),
      .word (data_q),
      .r    (exp_r),
      .g    (exp_g),
      .b    (exp_b)
   );

`ifdef VGA_UNPACK_OUTREG_EN
   logic [23:0] sk0_q, sk1_q;
   logic [1:0]  sk_cnt_q;
   logic        sk_pop;

   // ready depends only on skid occupancy, so pix_ready_i never reaches word_ready
   assign core_ready      = (sk_cnt_q != 2'd2);
   assign sk_pop          = bus.pix_valid_o & bus.pix_ready_i;
   assign bus.pix_valid_o = en_i & (sk_cnt_q != 2'd0);
   assign bus.pix_r_o     = bus.pix_valid_o ? sk0_q[23:16] : '0;
   assign bus.pix_g_o     = bus.pix_valid_o ? sk0_q[15:8]  : '0;
   assign bus.pix_b_o     = bus.pix_valid_o ? sk0_q[7:0]   : '0;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sk0_q    <= '0;
         sk1_q    <= '0;
         sk_cnt_q <= '0;
      end else if (flush_i) begin
         sk_cnt_q <= '0;
      end else begin
         case ({core_fire, sk_pop})
            2'b10: begin
               if (sk_cnt_q == 2'd0) sk0_q <= {exp_r, exp_g, exp_b};
               else                  sk1_q <= {exp_r, exp_g, exp_b};
               sk_cnt_q <= sk_cnt_q + 2'd1;
            end
            2'b01: begin
               sk0_q    <= sk1_q;
               sk_cnt_q <= sk_cnt_q - 2'd1;
            end
            2'b11: begin
               if (sk_cnt_q == 2'd1) begin
                  sk0_q <= {exp_r, exp_g, exp_b};
               end else begin
                  sk0_q <= sk1_q;
                  sk1_q <= {exp_r, exp_g, exp_b};
               end
            end
            default: ;
         endcase
      end
   end
`else
   assign core_ready      = bus.pix_ready_i;
   assign bus.pix_valid_o = core_valid;
   assign bus.pix_r_o     = core_valid ? exp_r : '0;
   assign bus.pix_g_o     = core_valid ? exp_g : '0;
   assign bus.pix_b_o     = core_valid ? exp_b : '0;
`endif

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Self-checking bench for vga_pixel_unpack: directed test-plan sequences then random traffic,
// all checked against a queue-of-pixels reference model.
module tb_vga_pixel_unpack;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       en_i;
   logic       flush_i;
   logic [1:0] mode_i;
   logic       underrun_o;

   vga_pixel_unpack_if #(.DATA_WIDTH(64), .COLOR_WIDTH(8)) bus ();

   vga_pixel_unpack #(.DATA_WIDTH(64), .COLOR_WIDTH(8)) dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .en_i       (en_i),
      .flush_i    (flush_i),
      .mode_i     (mode_i),
      .bus        (bus.slave),
      .underrun_o (underrun_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic [23:0] exp_q[$];
   logic        exp_ur = 1'b0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int ref_pixels(input logic [1:0] mode);
      case (mode)
         2'b00:   ref_pixels = 8;
         2'b01:   ref_pixels = 4;
         default: ref_pixels = 2;
      endcase
   endfunction

   function automatic logic [23:0] ref_pixel(input logic [1:0] mode, input logic [63:0] word, input int k);
      logic [63:0] p;
      logic [7:0]  r, g, b;
      case (mode)
         2'b00: begin
            p = (word >> (8 * k)) & 64'hFF;
            r = p[7:0]; g = p[7:0]; b = p[7:0];
         end
         2'b01: begin
            p = (word >> (16 * k)) & 64'hFFFF;
            r = 8'(((p >> 11) & 64'h1F) * 8 + ((p >> 13) & 64'h7));
            g = 8'(((p >> 5) & 64'h3F) * 4 + ((p >> 9) & 64'h3));
            b = 8'((p & 64'h1F) * 8 + ((p >> 2) & 64'h7));
         end
         default: begin
            p = (word >> (32 * k)) & 64'hFFFF_FFFF;
            r = 8'(p >> 16); g = 8'(p >> 8); b = 8'(p);
         end
      endcase
      ref_pixel = {r, g, b};
   endfunction

   // One clock: drive at negedge, check settled outputs, then advance the model.
   task automatic step(input logic en, input logic fl, input logic [1:0] md,
                       input logic wv, input logic [63:0] wd, input logic pr);
      logic exp_wr;
      logic have;
      @(negedge clk_i);
      en_i = en; flush_i = fl; mode_i = md;
      bus.word_valid_i = wv; bus.word_data_i = wd; bus.pix_ready_i = pr;
      #1;
      have = (exp_q.size() > 0);
      check("underrun", 64'(underrun_o), 64'(exp_ur));
      if (!fl) begin
         check("pix_valid", 64'(bus.pix_valid_o), 64'(en && have));
         if (en && have) check("pix_rgb", 64'({bus.pix_r_o, bus.pix_g_o, bus.pix_b_o}), 64'(exp_q[0]));
         else            check("pix_zero", 64'({bus.pix_r_o, bus.pix_g_o, bus.pix_b_o}), 64'd0);
      end
      exp_wr = en && !fl && (!have || (exp_q.size() == 1 && pr));
      check("word_ready", 64'(bus.word_ready_o), 64'(exp_wr));
      exp_ur = !fl && en && pr && !have;
      if (fl) begin
         exp_q.delete();
      end else begin
         if (en && pr && have) void'(exp_q.pop_front());
         if (exp_wr && wv)
            for (int k = 0; k < ref_pixels(md); k++) exp_q.push_back(ref_pixel(md, wd, k));
      end
   endtask

   initial begin
      logic [63:0] w565, w8a, w8b, wx, wr;
      w565 = 64'h001F_07E0_F800_FFFF;
      w8a  = 64'h0706_0504_0302_0100;
      w8b  = 64'h0F0E_0D0C_0B0A_0908;
      wx   = 64'hAA12_3456_55AB_CDEF;

      rst_n_i = 1'b0; en_i = 1'b0; flush_i = 1'b0; mode_i = 2'b00;
      bus.word_valid_i = 1'b0; bus.word_data_i = '0; bus.pix_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_pix_valid", 64'(bus.pix_valid_o), 64'd0);
      check("rst_word_ready", 64'(bus.word_ready_o), 64'd0);
      check("rst_rgb", 64'({bus.pix_r_o, bus.pix_g_o, bus.pix_b_o}), 64'd0);
      check("rst_underrun", 64'(underrun_o), 64'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // RGB565 word, then FIFO runs dry -> underrun
      step(1, 0, 2'b01, 1, w565, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 2'b01, 0, '0, 1);
      step(1, 0, 2'b01, 0, '0, 1);
      step(1, 0, 2'b01, 0, '0, 0);

      // 8bpp back-to-back words
      step(1, 0, 2'b00, 1, w8a, 1);
      for (int i = 0; i < 8; i++) step(1, 0, 2'b00, 1, w8b, 1);
      for (int i = 0; i < 8; i++) step(1, 0, 2'b00, 0, '0, 1);

      // XRGB8888
      step(1, 0, 2'b10, 1, wx, 1);
      for (int i = 0; i < 2; i++) step(1, 0, 2'b10, 0, '0, 1);

      // disabled with FIFO empty: no underrun
      for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 0, '0, 1);

      // flush at lane 2, next word restarts at pixel 0
      step(1, 0, 2'b00, 1, w8a, 0);
      for (int i = 0; i < 2; i++) step(1, 0, 2'b00, 0, '0, 1);
      step(1, 1, 2'b00, 1, w8b, 1);
      step(1, 0, 2'b00, 1, w8b, 1);
      for (int i = 0; i < 8; i++) step(1, 0, 2'b00, 0, '0, 1);

      // mode changed mid-word takes effect at the next word
      step(1, 0, 2'b01, 1, w565, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 2'b10, 1, wx, 1);
      for (int i = 0; i < 2; i++) step(1, 0, 2'b10, 0, '0, 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         wr = {$urandom(), $urandom()};
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 7), wr, ($urandom_range(0, 9) < 8));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_pixel_unpack.md
Name: vga_pixel_unpack

Overview:
- Sits directly downstream of the 64-bit tx FIFO in the VGA controller, and upstream of the timing generator's pixel input.
- Pops one 64-bit frame-buffer word at a time, splits it into 8, 4 or 2 pixels according to the colour mode, and expands each pixel to 8-bit R/G/B.
- Presents the pixels on a valid/ready stream, one per accepted handshake.
- Flags underrun when the timing generator requests a pixel that is not available.

Parameters:
- DATA_WIDTH, 64, FIFO word width; fixed at 64. Any other value is a compile-time error.
- COLOR_WIDTH, 8, per-channel output width.

Ports:
- clk_i  in  1  pixel-domain clock (single clock)
- rst_n_i  in  1  asynchronous active-low reset
- en_i  in  1  block enable; when 0, no word is popped and pix_valid_o=0
- flush_i  in  1  synchronous flush of held word and lane index
- mode_i  in  2  00=8bpp grey, 01=RGB565, 10=XRGB8888, 11=reserved (decoded as 10)
- word_valid_i  in  1  FIFO not empty
- word_ready_o  out  1  FIFO pop
- word_data_i  in  64  FIFO head word
- pix_valid_o  out  1  pixel available
- pix_ready_i  in  1  timing generator consumes pixel (active display)
- pix_r_o  out  8  red
- pix_g_o  out  8  green
- pix_b_o  out  8  blue
- underrun_o  out  1  one-cycle pulse on starvation

Behaviour:
- Reset values: word_ready_o=0, pix_valid_o=0, pix_r/g/b_o=0, underrun_o=0.
- Internal state: data_q[63:0], lane_q[2:0], mode_q[1:0], full_q.
- State machine, two states:
  - EMPTY (full_q=0): word_ready_o = en_i & ~flush_i.
    - On word_valid_i & word_ready_o: load data_q, set mode_q=mode_i, lane_q=0, go to FULL.
  - FULL (full_q=1): pix_valid_o = en_i.
    - On pix_valid_o & pix_ready_i: lane_q increments.
    - If lane_q == last lane (7 / 3 / 1 for mode_q 00 / 01 / 1x):
      - word_ready_o is asserted combinationally in the same cycle.
      - If word_valid_i, load the next word (back-to-back, no bubble).
      - Otherwise go to EMPTY.
- Latency: a word accepted in cycle N gives its pixel 0 at cycle N+1. Sustained throughput is 1 pixel/clk.
- Lane ordering is little-endian: pixel k occupies bits [k*bpp +: bpp].
- Expansion rules:
  - 8bpp: R=G=B=byte.
  - RGB565: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}; r in bits [15:11], b in [4:0].
  - XRGB8888: R=[23:16], G=[15:8], B=[7:0]; bits [31:24] are ignored.
- Pixel outputs are combinational from registered state only. There is no path from pix_ready_i to pix data.
- Outputs are 0 when pix_valid_o=0.
- mode_i is sampled only at word load. A mode change takes effect at the next word boundary.
- flush_i takes priority over every other event: full_q=0, lane_q=0, no pop in that cycle, underrun_o=0.
- en_i=0: the held word is retained, pix_valid_o=0, no pop, no underrun.
- underrun_o = en_i & pix_ready_i & ~pix_valid_o, registered, so it appears one cycle later.
- Reset asserted mid-word: the word is lost; the frame restarts after upstream re-aligns by flushing.

Optional Feature:
- Macro VGA_UNPACK_OUTREG_EN.
- When defined:
  - A registered output stage (2-entry skid) follows the combinational expansion.
  - Pixel latency becomes N+2; throughput stays 1 pixel/clk.
  - pix_ready_i does not combinationally reach word_ready_o.
  - flush_i also clears the skid entries.
- When undefined: behaviour is as described above.

Decomposition:
- Shared package vga_pkg holds:
  - the mode enum (VGA_MODE_GREY8, VGA_MODE_RGB565, VGA_MODE_XRGB8888);
  - the state enum;
  - a function mode_last_lane(mode) returning 3 bits;
  - per-mode bpp constants.
- One natural sub-module, vga_pixel_expand: purely combinational, taking mode, lane and 64-bit word and producing R/G/B.
- The skid buffer reuses the team's existing register primitives.

Test Plan:
- RGB565, word 0x001F_07E0_F800_FFFF, pix_ready_i=1 → 4 pixels (FF,FF,FF),(FF,00,00),(00,FF,00),(00,00,FF), then word_ready_o pulses once.
- 8bpp, word 0x0706050403020100 → 8 pixels, grey 00..07 in order, back-to-back with the next word and no bubble cycle.
- XRGB8888, word 0xAA123456_55ABCDEF → (AB,CD,EF) then (12,34,56); the X byte is ignored.
- FIFO empty while pix_ready_i=1, en_i=1 → pix_valid_o=0 and underrun_o=1 the following cycle; no underrun when en_i=0.
- flush_i mid-word at lane 2 → next cycle pix_valid_o=0 and lane_q=0; the following word starts at pixel 0.
- mode_i switched 01→10 mid-word → the remaining lanes still decode as RGB565, and the next word decodes as XRGB8888.
